// File: rtl/ysyx_23060240_ifu_fetch_pkg.sv
// Shared core definitions for the instruction fetch unit: state encoding and AXI response codes.
package ysyx_23060240_ifu_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned RESP_W  = 2;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_AR      = 3'd1;
  localparam logic [STATE_W-1:0] ST_R       = 3'd2;
  localparam logic [STATE_W-1:0] ST_OUT     = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_PC = 3'd4;
  localparam logic [STATE_W-1:0] ST_HALT    = 3'd5;

  localparam logic [RESP_W-1:0] RESP_OKAY = 2'b00;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = ST_IDLE,
    S_AR      = ST_AR,
    S_R       = ST_R,
    S_OUT     = ST_OUT,
    S_WAIT_PC = ST_WAIT_PC,
    S_HALT    = ST_HALT
  } fetch_state_e;

endpackage

// File: rtl/ysyx_23060240_ifu_fetch.sv
// Instruction fetch unit: one outstanding AXI-lite read per instruction, hands the word to the IDU
// and waits for the next PC from writeback before issuing the following fetch.
module ysyx_23060240_ifu_fetch
  import ysyx_23060240_ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] maxi_araddr,
  output logic        maxi_arvalid,
  input  logic        maxi_arready,
  input  logic        maxi_rvalid,
  output logic        maxi_rready,
  input  logic [31:0] maxi_rdata,
  input  logic [1:0]  maxi_rresp,
  input  logic        dnpc_valid,
  input  logic [31:0] dnpc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic [31:0] fetch_cnt
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic            inst_err_q, inst_err_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            inst_valid_q, inst_valid_d;
  logic            ar_hs, r_hs, inst_hs;

  // Next-state and datapath; handshake strobes are registered as a decode of the next state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    inst_err_d  = inst_err_q;
    fetch_cnt_d = fetch_cnt_q;
    ar_hs       = arvalid_q && maxi_arready;
    r_hs        = rready_q && maxi_rvalid;
    inst_hs     = inst_valid_q && inst_ready;

    case (state_q)
      S_IDLE: state_d = S_AR;
      S_AR: begin
        if (ar_hs) state_d = S_R;
      end
      S_R: begin
        if (r_hs) begin
          inst_d      = maxi_rdata;
          inst_pc_d   = pc_q;
          inst_err_d  = (maxi_rresp != RESP_OKAY);
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        // A next PC arriving with the handshake skips the WAIT_PC bubble.
        if (inst_hs) begin
          if (dnpc_valid) begin
            pc_d    = dnpc;
            state_d = halt ? S_HALT : S_AR;
          end else begin
            state_d = S_WAIT_PC;
          end
        end
      end
      S_WAIT_PC: begin
        if (dnpc_valid) pc_d = dnpc;
        if (halt) state_d = S_HALT;
        else if (dnpc_valid) state_d = S_AR;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    arvalid_d    = (state_d == S_AR);
    rready_d     = (state_d == S_R);
    inst_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_err_q   <= 1'b0;
      fetch_cnt_q  <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_err_q   <= inst_err_d;
      fetch_cnt_q  <= fetch_cnt_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign maxi_araddr  = pc_q;
  assign maxi_arvalid = arvalid_q;
  assign maxi_rready  = rready_q;
  assign inst_valid   = inst_valid_q;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign inst_err     = inst_err_q;
  assign fetch_cnt    = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_23060240_ifu_fetch.sv
// Directed bench for the fetch unit: the bench plays the AXI-lite slave and the IDU/writeback side,
// queuing the expected instruction at each R beat and comparing it when inst_valid appears.
module tb_ysyx_23060240_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] maxi_araddr;
  logic        maxi_arvalid;
  logic        maxi_arready;
  logic        maxi_rvalid;
  logic        maxi_rready;
  logic [31:0] maxi_rdata;
  logic [1:0]  maxi_rresp;
  logic        dnpc_valid;
  logic [31:0] dnpc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic [31:0] fetch_cnt;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_cnt = 32'd0;

  ysyx_23060240_ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .maxi_araddr(maxi_araddr), .maxi_arvalid(maxi_arvalid), .maxi_arready(maxi_arready),
    .maxi_rvalid(maxi_rvalid), .maxi_rready(maxi_rready), .maxi_rdata(maxi_rdata),
    .maxi_rresp(maxi_rresp), .dnpc_valid(dnpc_valid), .dnpc(dnpc), .halt(halt),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_err(inst_err), .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk1({tag, "_arvalid"}, maxi_arvalid, 1'b0);
    chk1({tag, "_rready"}, maxi_rready, 1'b0);
    chk1({tag, "_inst_valid"}, inst_valid, 1'b0);
    chk32({tag, "_inst"}, inst, 32'h0);
    chk32({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk1({tag, "_inst_err"}, inst_err, 1'b0);
    chk32({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
    chk32({tag, "_araddr"}, maxi_araddr, RESET_PC);
  endtask

  // Waits (bounded) for arvalid, stalls arready ar_wait cycles, then accepts the address.
  task automatic do_ar(input logic [31:0] addr, input int ar_wait, input logic noise);
    int t = 0;
    while (maxi_arvalid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk1("ar_seen", maxi_arvalid, 1'b1);
    chk32("araddr", maxi_araddr, addr);
    for (int i = 0; i < ar_wait; i++) begin
      if (noise) begin
        maxi_rvalid = 1'b1;
        maxi_rdata  = 32'hbad0_0000;
        dnpc_valid  = 1'b1;
        dnpc        = 32'h1234_5678;
        halt        = 1'b1;
      end
      @(negedge clk);
      chk1("ar_hold_valid", maxi_arvalid, 1'b1);
      chk32("ar_hold_addr", maxi_araddr, addr);
      chk1("ar_no_rready", maxi_rready, 1'b0);
      chk32("ar_cnt_stable", fetch_cnt, model_cnt);
    end
    maxi_rvalid  = 1'b0;
    dnpc_valid   = 1'b0;
    halt         = 1'b0;
    maxi_arready = 1'b1;
    @(negedge clk);
    maxi_arready = 1'b0;
    chk1("ar_done_arvalid", maxi_arvalid, 1'b0);
    chk1("r_rready", maxi_rready, 1'b1);
  endtask

  // Returns the beat one cycle after the AR handshake; inst_valid must follow immediately.
  task automatic do_r(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    exp_t e;
    e.inst = data;
    e.pc   = addr;
    e.err  = (resp != 2'b00);
    sb.push_back(e);
    maxi_rvalid = 1'b1;
    maxi_rdata  = data;
    maxi_rresp  = resp;
    @(negedge clk);
    maxi_rvalid = 1'b0;
    maxi_rdata  = 32'h0;
    maxi_rresp  = 2'b00;
    model_cnt   = model_cnt + 32'd1;
    chk1("latency_inst_valid", inst_valid, 1'b1);
    chk1("r_done_rready", maxi_rready, 1'b0);
    chk32("fetch_cnt", fetch_cnt, model_cnt);
    chk1("sb_has_entry", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk32("inst", inst, e.inst);
      chk32("inst_pc", inst_pc, e.pc);
      chk1("inst_err", inst_err, e.err);
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input int ar_wait, input logic noise,
                       input logic [31:0] data, input logic [1:0] resp);
    do_ar(addr, ar_wait, noise);
    do_r(addr, data, resp);
  endtask

  // Stalls inst_ready (with a stray dnpc_valid), then handshakes with the given next-PC inputs.
  task automatic consume(input int ready_wait, input logic dv, input logic [31:0] dpc, input logic h);
    logic [31:0] held_inst = inst;
    logic [31:0] held_pc   = inst_pc;
    for (int i = 0; i < ready_wait; i++) begin
      dnpc_valid = 1'b1;
      dnpc       = 32'hdead_0000;
      @(negedge clk);
      chk1("out_hold_valid", inst_valid, 1'b1);
      chk32("out_hold_inst", inst, held_inst);
      chk32("out_hold_pc", inst_pc, held_pc);
      chk1("out_no_ar", maxi_arvalid, 1'b0);
    end
    inst_ready = 1'b1;
    dnpc_valid = dv;
    dnpc       = dpc;
    halt       = h;
    @(negedge clk);
    inst_ready = 1'b0;
    dnpc_valid = 1'b0;
    halt       = 1'b0;
    chk1("out_done_valid", inst_valid, 1'b0);
    chk1("next_arvalid", maxi_arvalid, dv && !h);
    if (dv && !h) chk32("next_araddr", maxi_araddr, dpc);
  endtask

  task automatic provide_pc(input logic [31:0] dpc, input logic h);
    dnpc_valid = 1'b1;
    dnpc       = dpc;
    halt       = h;
    @(negedge clk);
    dnpc_valid = 1'b0;
    halt       = 1'b0;
    chk1("wait_pc_arvalid", maxi_arvalid, !h);
    if (!h) chk32("wait_pc_araddr", maxi_araddr, dpc);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset(tag);
    rst = 1'b0;
    model_cnt = 32'd0;
    sb.delete();
    chk1("release_arvalid_low", maxi_arvalid, 1'b0);
    @(negedge clk);
    chk1("release_arvalid_high", maxi_arvalid, 1'b1);
    chk32("release_araddr", maxi_araddr, RESET_PC);
  endtask

  initial begin
    int busy;
    rst          = 1'b1;
    maxi_arready = 1'b0;
    maxi_rvalid  = 1'b0;
    maxi_rdata   = 32'h0;
    maxi_rresp   = 2'b00;
    dnpc_valid   = 1'b0;
    dnpc         = 32'h0;
    halt         = 1'b0;
    inst_ready   = 1'b0;
    repeat (3) @(negedge clk);
    reset_pulse("por");

    // Basic fetch, then a 3-cycle IDU stall released together with the next PC.
    fetch(RESET_PC, 0, 1'b0, 32'h0000_0413, 2'b00);
    consume(3, 1'b1, 32'h8000_0004, 1'b0);

    // Slave stalls arready 5 cycles while rvalid/dnpc_valid/halt noise is driven; SLVERR beat.
    fetch(32'h8000_0004, 5, 1'b1, 32'h0010_0093, 2'b10);
    consume(0, 1'b0, 32'h0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk1("wait_pc_idle", maxi_arvalid, 1'b0);
    end
    provide_pc(32'h8000_0010, 1'b0);

    // OKAY response clears the error flag; then halt together with dnpc in WAIT_PC.
    fetch(32'h8000_0010, 0, 1'b0, 32'h0020_8113, 2'b00);
    consume(1, 1'b0, 32'h0, 1'b0);
    provide_pc(32'h8000_0020, 1'b1);
    busy = 0;
    maxi_arready = 1'b1;
    maxi_rvalid  = 1'b1;
    inst_ready   = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (maxi_arvalid || maxi_rready || inst_valid) busy++;
    end
    maxi_arready = 1'b0;
    maxi_rvalid  = 1'b0;
    inst_ready   = 1'b0;
    chk32("halt_quiet_cycles", 32'(busy), 32'd0);
    chk32("halt_cnt_frozen", fetch_cnt, model_cnt);

    reset_pulse("halt_rst");
    fetch(RESET_PC, 1, 1'b0, 32'h0000_0013, 2'b00);
    consume(0, 1'b1, 32'h8000_0008, 1'b0);

    // Reset lands while the R beat is pending: the beat must be dropped.
    do_ar(32'h8000_0008, 0, 1'b0);
    maxi_rvalid = 1'b1;
    maxi_rdata  = 32'h1234_5678;
    rst         = 1'b1;
    @(negedge clk);
    maxi_rvalid = 1'b0;
    check_reset("abort");
    reset_pulse("abort_rst");
    fetch(RESET_PC, 0, 1'b0, 32'h0000_0073, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060240_ifu_fetch.md
YSYX_23060240_IFU_FETCH -- requirements
Module: ysyx_23060240_ifu_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- maxi_araddr  out  32  AXI-lite read address.
- maxi_arvalid  out  1  read address valid.
- maxi_arready  in  1  read address ready.
- maxi_rvalid  in  1  read data valid.
- maxi_rready  out  1  read data ready.
- maxi_rdata  in  32  read data (instruction).
- maxi_rresp  in  2  read response; 2'b00 = OKAY.
- dnpc_valid  in  1  next-PC valid from writeback.
- dnpc  in  32  next PC value.
- halt  in  1  stop fetching (ebreak/finish).
- inst_valid  out  1  instruction valid to IDU.
- inst_ready  in  1  IDU accepts instruction.
- inst  out  32  fetched instruction.
- inst_pc  out  32  PC of inst.
- inst_err  out  1  rresp was non-OKAY for this inst.
- fetch_cnt  out  32  completed R handshakes since reset.

Function
REQ-003 SHALL implement FSM states IDLE, AR, R, OUT, WAIT_PC, HALT.
REQ-004 SHALL go IDLE->AR unconditionally one cycle after reset release; maxi_arvalid rises in the first cycle after rst deasserts.
REQ-005 SHALL drive maxi_arvalid=1 and maxi_araddr=pc only in AR; AR->R on arvalid&&arready.
REQ-006 SHALL hold maxi_araddr stable and maxi_arvalid asserted until the AR handshake; neither halt nor dnpc_valid may withdraw it.
REQ-007 SHALL drive maxi_rready=1 only in R; on rvalid&&rready, register rdata into inst, (rresp!=0) into inst_err, increment fetch_cnt, then R->OUT.
REQ-008 SHALL ignore maxi_rvalid outside R.
REQ-009 SHALL assert inst_valid only in OUT, with inst, inst_pc and inst_err held stable until inst_ready.
REQ-010 SHALL go OUT->WAIT_PC on inst_valid&&inst_ready when dnpc_valid=0.
REQ-011 SHALL, on inst handshake coinciding with dnpc_valid=1 in OUT, load pc<=dnpc and go directly to AR (or HALT if halt=1).
REQ-012 SHALL, in WAIT_PC with dnpc_valid=1, load pc<=dnpc and go to AR; if halt=1 in the same cycle, go to HALT with pc still loaded.
REQ-013 SHALL ignore dnpc_valid in IDLE, AR, R, HALT, and in OUT without inst handshake.
REQ-014 SHALL enter HALT from WAIT_PC when halt=1 regardless of dnpc_valid; HALT holds all handshake outputs low until reset.
REQ-015 SHALL never issue a second AR before the preceding R handshake completes (one outstanding transaction).
REQ-016 SHALL keep dnpc width 32 with no alignment check; fetch_cnt wraps 32'hFFFF_FFFF->0.
REQ-017 SHALL give minimum fetch latency AR-issue to inst_valid of 2 cycles (AR accepted in cycle n, rvalid in n+1, inst_valid in n+2).

Reset
REQ-018 SHALL, while rst=1: state=IDLE, pc=RESET_PC, maxi_arvalid=0, maxi_rready=0, inst_valid=0, inst=0, inst_pc=0, inst_err=0, fetch_cnt=0, maxi_araddr=RESET_PC.
REQ-019 SHALL abandon any in-flight transaction on rst asserted mid-AR or mid-R; slave is reset by the same rst.

Structure
REQ-020 SHALL place state encoding (3-bit localparams) and RESP_OKAY in the shared core package; RESET_PC stays a module parameter.
REQ-021 SHALL be a single module; no sub-module.

Verification
REQ-022 Reset release, slave arready=1, rdata=32'h00000413 after 1 cycle -> araddr=32'h80000000, inst_valid 2 cycles after AR handshake, inst=32'h00000413, inst_pc=32'h80000000, fetch_cnt=1.
REQ-023 Slave arready low 5 cycles -> arvalid held 6 cycles, araddr constant, no rready before handshake.
REQ-024 inst_ready low 3 cycles in OUT -> inst/inst_pc stable, no new AR; then dnpc_valid with dnpc=32'h80000004 simultaneous with inst_ready -> next araddr=32'h80000004 in the following cycle.
REQ-025 rresp=2'b10 -> inst_err=1 with inst; next fetch after OKAY response -> inst_err=0.
REQ-026 halt=1 with dnpc_valid=1 in WAIT_PC -> HALT, no further arvalid for 100 cycles; rst pulse -> fetch restarts at 32'h80000000, fetch_cnt=0.
REQ-027 rst asserted during R with rvalid pending -> outputs at reset values next cycle, fetch_cnt unchanged by the abandoned beat.
